// File: rtl/rf_wb_arbiter_pkg.sv
// rf_pkg: shared widths and requester encoding for the register-file
// writeback arbiter slice.
package rf_pkg;

  localparam int REG_W     = 16;
  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS  = 16;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  // Requester identity; also the meaning of the round-robin pointer value.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback request/accept handshakes, issue-side
// pending marks, register-file write port and scoreboard view.
interface rf_wb_arbiter_if;
  import rf_pkg::*;

  logic                 alu_valid;
  logic                 alu_ready;
  logic [REG_IDX_W-1:0] alu_dst;
  logic [REG_W-1:0]     alu_data;

  logic                 mem_valid;
  logic                 mem_ready;
  logic [REG_IDX_W-1:0] mem_dst;
  logic [REG_W-1:0]     mem_data;

  logic                 iss_valid;
  logic [REG_IDX_W-1:0] iss_dst;

  logic                 WriteReg;
  logic [REG_IDX_W-1:0] DstReg;
  logic [REG_W-1:0]     DstData;
  logic [NUM_REGS-1:0]  busy;

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_dst, alu_data,
    input  mem_valid, mem_dst, mem_data,
    input  iss_valid, iss_dst,
    output alu_ready, mem_ready,
    output WriteReg, DstReg, DstData, busy
  );

  // Requester / register-file side.
  modport master (
    output alu_valid, alu_dst, alu_data,
    output mem_valid, mem_dst, mem_data,
    output iss_valid, iss_dst,
    input  alu_ready, mem_ready,
    input  WriteReg, DstReg, DstData, busy
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter. Grants are combinational from the
// valids and the pointer; the pointer moves to the loser on every grant so
// back-to-back contention alternates.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  req_e rrPtr;

  // Grant the sole valid requester, or the pointed-to one under contention.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (valid[REQ_ALU] && (!valid[REQ_MEM] || rrPtr == REQ_ALU))
        grant[REQ_ALU] = 1'b1;
      else if (valid[REQ_MEM])
        grant[REQ_MEM] = 1'b1;
    end
  end

  // Pointer moves to whichever requester did not win this edge.
  always_ff @(posedge clk) begin
    if (rst)
      rrPtr <= REQ_ALU;
    else if (grant[REQ_ALU])
      rrPtr <= REQ_MEM;
    else if (grant[REQ_MEM])
      rrPtr <= REQ_ALU;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates ALU and load-unit writebacks onto a single
// register-file write port, one write per cycle, with registered outputs.
// Optional pending-write scoreboard enabled by macro RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter
  import rf_pkg::*;
(
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);

  logic [1:0]           grant;
  logic                 accept;
  logic [REG_IDX_W-1:0] selDst;
  logic [REG_W-1:0]     selData;

  logic                 writeVld_p1;
  logic [REG_IDX_W-1:0] dstReg_p1;
  logic [REG_W-1:0]     dstData_p1;

  rr_arb2 uArb (
    .clk   (clk),
    .rst   (rst),
    .valid ({bus.mem_valid, bus.alu_valid}),
    .grant (grant)
  );

  assign bus.alu_ready = grant[REQ_ALU];
  assign bus.mem_ready = grant[REQ_MEM];
  assign accept        = |grant;

  // Steer the winning requester's destination and data.
  always_comb begin
    selDst  = bus.alu_dst;
    selData = bus.alu_data;
    if (grant[REQ_MEM]) begin
      selDst  = bus.mem_dst;
      selData = bus.mem_data;
    end
  end

  // ---- stage p0 -> p1: register-file write port ----
  // Zero-register writes are accepted but never raise the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      writeVld_p1 <= 1'b0;
      dstReg_p1   <= '0;
      dstData_p1  <= '0;
    end else begin
      writeVld_p1 <= accept && (selDst != ZERO_REG);
      if (accept) begin
        dstReg_p1  <= selDst;
        dstData_p1 <= selData;
      end
    end
  end

  assign bus.WriteReg = writeVld_p1;
  assign bus.DstReg   = dstReg_p1;
  assign bus.DstData  = dstData_p1;

`ifdef RF_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busyQ;
  logic [NUM_REGS-1:0] busyNext;

  // Clear on accepted writeback, then set on issue so a same-index set wins.
  always_comb begin
    busyNext = busyQ;
    if (accept && (selDst != ZERO_REG))
      busyNext[selDst] = 1'b0;
    if (bus.iss_valid && (bus.iss_dst != ZERO_REG))
      busyNext[bus.iss_dst] = 1'b1;
    busyNext[ZERO_REG] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst)
      busyQ <= '0;
    else
      busyQ <= busyNext;
  end

  assign bus.busy = busyQ;
`else
  wire unusedIss = ^{bus.iss_valid, bus.iss_dst};
  assign bus.busy = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and randomized bench for rf_wb_arbiter with a
// behavioural reference model; follows RF_WB_SCOREBOARD_EN like the design.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          mRr;
  bit          mWr;
  logic [3:0]  mDst;
  logic [15:0] mData;
  bit   [15:0] mBusy;
  bit          lastAluAcc;
  bit          lastMemAcc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit expAluRdy();
    return !rst && bus.alu_valid && (!bus.mem_valid || mRr == 1'b0);
  endfunction

  function automatic bit expMemRdy();
    return !rst && bus.mem_valid && (!bus.alu_valid || mRr == 1'b1);
  endfunction

  task automatic modelStep();
    bit          aR;
    bit          mR;
    logic [3:0]  d;
    logic [15:0] v;
    aR = expAluRdy();
    mR = expMemRdy();
    lastAluAcc = aR;
    lastMemAcc = mR;
    if (rst) begin
      mRr = 0; mWr = 0; mDst = '0; mData = '0; mBusy = '0;
    end else begin
      mWr = 0;
      if (aR || mR) begin
        d     = aR ? bus.alu_dst  : bus.mem_dst;
        v     = aR ? bus.alu_data : bus.mem_data;
        mRr   = aR ? 1'b1 : 1'b0;
        mWr   = (d != 4'd0);
        mDst  = d;
        mData = v;
`ifdef RF_WB_SCOREBOARD_EN
        if (d != 4'd0) mBusy[d] = 1'b0;
`endif
      end
`ifdef RF_WB_SCOREBOARD_EN
      if (bus.iss_valid && bus.iss_dst != 4'd0) mBusy[bus.iss_dst] = 1'b1;
`endif
    end
  endtask

  // One clock: compare everything mid-cycle, then advance the model at the edge.
  task automatic cycle();
    @(negedge clk);
    chk("alu_ready", 32'(bus.alu_ready), 32'(expAluRdy()));
    chk("mem_ready", 32'(bus.mem_ready), 32'(expMemRdy()));
    chk("WriteReg",  32'(bus.WriteReg),  32'(mWr));
    chk("DstReg",    32'(bus.DstReg),    32'(mDst));
    chk("DstData",   32'(bus.DstData),   32'(mData));
    chk("busy",      32'(bus.busy),      32'(mBusy));
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic setIn(input bit av, input logic [3:0] ad, input logic [15:0] adata,
                       input bit mv, input logic [3:0] md, input logic [15:0] mdata,
                       input bit iv, input logic [3:0] id);
    bus.alu_valid = av; bus.alu_dst = ad; bus.alu_data = adata;
    bus.mem_valid = mv; bus.mem_dst = md; bus.mem_data = mdata;
    bus.iss_valid = iv; bus.iss_dst = id;
  endtask

  initial begin
    logic [31:0] r;
    bit          expAluOrder [4];
    logic [3:0]  expDstOrder [4];
    expAluOrder = '{1'b1, 1'b0, 1'b1, 1'b0};
    expDstOrder = '{4'd1, 4'd2, 4'd1, 4'd2};

    mRr = 0; mWr = 0; mDst = '0; mData = '0; mBusy = '0;
    lastAluAcc = 0; lastMemAcc = 0;
    rst = 1'b1;
    setIn(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0);
    #1;
    repeat (3) cycle();
    chk("reset_WriteReg", 32'(bus.WriteReg), 32'd0);
    chk("reset_DstData",  32'(bus.DstData),  32'd0);
    chk("reset_busy",     32'(bus.busy),     32'd0);

    // ALU alone: ready same cycle, write visible next cycle
    rst = 1'b0;
    setIn(1, 4'd3, 16'h1234, 0, 4'd0, 16'h0, 0, 4'd0);
    #1;
    chk("alu_only_ready", 32'(bus.alu_ready), 32'd1);
    cycle();
    chk("alu_only_WriteReg", 32'(bus.WriteReg), 32'd1);
    chk("alu_only_DstReg",   32'(bus.DstReg),   32'd3);
    chk("alu_only_DstData",  32'(bus.DstData),  32'h1234);
    setIn(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0);
    cycle();

    // Contention from reset alternates ALU, MEM, ALU, MEM
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    setIn(1, 4'd1, 16'hAAAA, 1, 4'd2, 16'h5555, 0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_alu_grant", 32'(bus.alu_ready), 32'(expAluOrder[i]));
      cycle();
      chk("rr_DstReg", 32'(bus.DstReg), 32'(expDstOrder[i]));
    end

    // Zero-register MEM write: accepted, no write enable, pointer still moves
    setIn(1, 4'd4, 16'h0004, 0, 4'd0, 16'h0, 0, 4'd0);
    cycle();
    setIn(0, 4'd0, 16'h0, 1, 4'd0, 16'hFFFF, 0, 4'd0);
    #1;
    chk("zero_mem_ready", 32'(bus.mem_ready), 32'd1);
    cycle();
    chk("zero_WriteReg", 32'(bus.WriteReg), 32'd0);
    chk("zero_DstData",  32'(bus.DstData),  32'hFFFF);
    setIn(1, 4'd6, 16'h0606, 1, 4'd7, 16'h0707, 0, 4'd0);
    #1;
    chk("zero_next_alu", 32'(bus.alu_ready), 32'd1);
    cycle();
    setIn(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0);
    cycle();

`ifdef RF_WB_SCOREBOARD_EN
    setIn(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'd5);
    cycle();
    chk("sb_set", 32'(bus.busy), 32'h0020);
    setIn(0, 4'd0, 16'h0, 1, 4'd5, 16'h5050, 0, 4'd0);
    cycle();
    chk("sb_clear", 32'(bus.busy), 32'h0000);
    setIn(1, 4'd5, 16'h5151, 0, 4'd0, 16'h0, 1, 4'd5);
    cycle();
    chk("sb_set_wins", 32'(bus.busy), 32'h0020);
`else
    setIn(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'd7);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("sb_off_busy", 32'(bus.busy), 32'h0000);
    end
`endif

    // Reset while both requesters are valid
    setIn(1, 4'd8, 16'h8888, 1, 4'd9, 16'h9999, 0, 4'd0);
    cycle();
    rst = 1'b1;
    #1;
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    cycle();
    chk("rst_WriteReg", 32'(bus.WriteReg), 32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    rst = 1'b0;
    #1;
    chk("rst_first_alu", 32'(bus.alu_ready), 32'd1);
    cycle();

    // Randomized traffic; requesters hold until accepted or occasionally withdraw
    for (int i = 0; i < 600; i++) begin
      if (!bus.alu_valid || lastAluAcc || $urandom_range(0, 9) == 0) begin
        r = $urandom;
        bus.alu_valid = (r[1:0] != 2'b00);
        bus.alu_dst   = r[7:4];
        bus.alu_data  = r[31:16];
      end
      if (!bus.mem_valid || lastMemAcc || $urandom_range(0, 9) == 0) begin
        r = $urandom;
        bus.mem_valid = (r[1:0] != 2'b00);
        bus.mem_dst   = r[7:4];
        bus.mem_data  = r[31:16];
      end
      r = $urandom;
      bus.iss_valid = r[0];
      bus.iss_dst   = r[7:4];
      rst = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Single clock and reset: synchronous, active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 alu_valid / alu_ready  in / out  1 / 1  ALU writeback request and accept handshake.
REQ-005 alu_dst / alu_data  in  4 / 16  ALU destination register index and write data.
REQ-006 mem_valid / mem_ready  in / out  1 / 1  load-unit writeback request and accept handshake.
REQ-007 mem_dst / mem_data  in  4 / 16  load destination register index and write data.
REQ-008 iss_valid / iss_dst  in  1 / 4  issue stage marks a destination register as pending.
REQ-009 WriteReg  out  1  write enable to the register file.
REQ-010 DstReg / DstData  out  4 / 16  register-file write index and write data.
REQ-011 busy  out  16  per-register pending-write scoreboard.

Function
REQ-012 A transfer occurs on a requester when its valid and ready are both 1 at a rising edge.
REQ-013 Ready is combinational from valid and the round-robin pointer (rr).
REQ-014 Ready is 0 whenever the requester's own valid is 0.
REQ-015 If only one requester is valid, that requester gets ready=1.
REQ-016 If both requesters are valid, only the requester selected by rr gets ready=1.
REQ-017 rr is 1 bit; 0 = ALU priority, 1 = MEM priority; reset value 0.
REQ-018 On each transfer, rr points to the requester that did not win, so simultaneous requests alternate.
REQ-019 On a transfer, the outputs update at that edge:
  - WriteReg = 1 if the destination is nonzero, else 0
  - DstReg = destination, DstData = data
REQ-020 Without a transfer, WriteReg = 0 and DstReg/DstData hold their previous values.
REQ-021 Latency: accepted at edge k -> WriteReg high during cycle k..k+1 -> register file writes at edge k+1.
REQ-022 Destination 0 (zero register):
  - the request is accepted and rr updates
  - WriteReg stays 0
  - the scoreboard is unchanged
REQ-023 Throughput is one write per cycle.
REQ-024 The arbiter never holds the winner's ready low while that winner is valid.
REQ-025 Requesters hold valid, dst and data stable until accepted; a requester deasserting valid before acceptance loses nothing.

Reset
REQ-026 While rst=1, the following are 0 at the next edge: WriteReg, DstReg, DstData, rr, busy.
REQ-027 Readies are 0 while rst=1.
REQ-028 Reset mid-operation discards any pending request and all scoreboard state.
REQ-029 The first transfer may occur at the first edge with rst=0.

Configuration
REQ-030 Macro RF_WB_SCOREBOARD_EN controls the scoreboard.
REQ-031 With RF_WB_SCOREBOARD_EN defined:
  - iss_valid=1 with iss_dst!=0 sets busy[iss_dst] at the edge
  - a transfer with dst!=0 clears busy[dst] at the same edge it is accepted
  - simultaneous set and clear of the same index: set wins
  - busy[0] is constant 0
REQ-032 Without RF_WB_SCOREBOARD_EN: busy is constant 0, iss_valid/iss_dst are ignored, and no scoreboard flops exist.

Structure
REQ-033 Shared package rf_pkg holds:
  - REG_W=16, REG_IDX_W=4, NUM_REGS=16, ZERO_REG=0
  - requester enum {REQ_ALU, REQ_MEM}
REQ-034 Sub-module rr_arb2 holds the 2-way round-robin arbiter: valid inputs, grant outputs, rr pointer state.
REQ-035 rf_wb_arbiter instantiates rr_arb2 once and holds the output registers and scoreboard.

Verification
REQ-036 ALU only: alu_valid, alu_dst=3, alu_data=0x1234 -> alu_ready=1 same cycle; next cycle WriteReg=1, DstReg=3, DstData=0x1234.
REQ-037 Both valid for 4 cycles from reset, ALU dst=1/data=0xAAAA, MEM dst=2/data=0x5555 -> grants in the order ALU, MEM, ALU, MEM; DstReg sequence 1,2,1,2.
REQ-038 MEM dst=0, data=0xFFFF -> mem_ready=1, WriteReg stays 0, rr toggles (next contention goes to ALU).
REQ-039 Scoreboard (macro on):
  - iss_dst=5 -> busy=0x0020
  - MEM write dst=5 -> busy=0x0000
  - same-cycle iss_dst=5 and transfer dst=5 -> busy[5]=1
REQ-040 Macro off: iss_valid=1, iss_dst=7 -> busy=0x0000 throughout.
REQ-041 Reset: rst asserted while both requesters are valid -> readies 0; next edge WriteReg=0, busy=0, rr=0; first grant after release goes to ALU.
